// File: rtl/mcu_pkg.sv
// rtl/mcu_pkg.sv - shared types and constants for the multi-channel MCU
package mcu_pkg;

    typedef enum logic [2:0] {
        IDLE,
        KEY_READ,
        KEY_GEN,
        DATA_REQ,
        DATA_DEQ,
        DATA_BUSY
    } mcu_state_t;

    // bit positions inside each channel's 4-bit status nibble
    localparam int ST_RXFULL = 0;
    localparam int ST_TXNE   = 1;
    localparam int ST_ENC    = 2;
    localparam int ST_KEYV   = 3;

    // channel index width, never narrower than one bit
    function automatic int ch_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mcu_multi_ch_if.sv
// rtl/mcu_multi_ch_if.sv - FIFO, key generator and cipher core handshakes of the MCU
interface mcu_multi_ch_if import mcu_pkg::*; #(
    parameter int NUM_CH = 2,
    parameter int CH_W   = ch_width(NUM_CH)
);
    logic              key_in;
    logic [CH_W-1:0]   key_ch;
    logic [NUM_CH-1:0] rx_empty;
    logic [NUM_CH-1:0] rx_full;
    logic [NUM_CH-1:0] tx_empty;
    logic [NUM_CH-1:0] tx_full;
    logic              generation_done;
    logic              accepted;
    logic              data_done;
    logic              read_fifo;
    logic              mcu_key_in;
    logic [NUM_CH-1:0] rcv_deq;
    logic [NUM_CH-1:0] trans_enq;
    logic [CH_W-1:0]   cur_ch;
    logic              core_is_encrypt;

    modport master (
        input  key_in, key_ch, rx_empty, rx_full, tx_empty, tx_full,
               generation_done, accepted, data_done,
        output read_fifo, mcu_key_in, rcv_deq, trans_enq, cur_ch, core_is_encrypt
    );

    modport slave (
        output key_in, key_ch, rx_empty, rx_full, tx_empty, tx_full,
               generation_done, accepted, data_done,
        input  read_fifo, mcu_key_in, rcv_deq, trans_enq, cur_ch, core_is_encrypt
    );
endinterface

// File: rtl/mcu_rr_arbiter.sv
// rtl/mcu_rr_arbiter.sv - combinational round-robin grant starting at a pointer
module mcu_rr_arbiter import mcu_pkg::*; #(
    parameter int NUM_CH = 2,
    parameter int CH_W   = ch_width(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [CH_W-1:0]   ptr,
    output logic [NUM_CH-1:0] grant,
    output logic [CH_W-1:0]   idx,
    output logic              any_grant
);
    int cand;

    // scan from farthest to nearest offset so the last hit is the one closest to ptr
    always_comb begin
        grant     = '0;
        idx       = '0;
        any_grant = 1'b0;
        cand      = 0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            cand = (int'(ptr) + k) % NUM_CH;
            if (req[cand]) begin
                grant       = '0;
                grant[cand] = 1'b1;
                idx         = CH_W'(cand);
                any_grant   = 1'b1;
            end
        end
    end
endmodule

// File: rtl/mcu_multi_ch.sv
// rtl/mcu_multi_ch.sv - multi-channel key load and block dispatch controller
module mcu_multi_ch import mcu_pkg::*; #(
    parameter int NUM_CH      = 2,
    parameter int KEY_WORDS   = 4,
    parameter int GEN_TIMEOUT = 64,
    parameter int CH_W        = ch_width(NUM_CH)
) (
    input  logic                  clk,
    input  logic                  reset,
    mcu_multi_ch_if.master        bus,
    input  logic [NUM_CH-1:0]     enc_pulse,
    input  logic [NUM_CH-1:0]     dec_pulse,
    output logic                  gen_error,
    output logic [4*NUM_CH-1:0]   status_bits
);
    localparam int CNT_W = $clog2(KEY_WORDS + 1);
    localparam int TMR_W = $clog2(GEN_TIMEOUT);
    localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(KEY_WORDS - 1);
    localparam logic [TMR_W-1:0] LAST_TICK = TMR_W'(GEN_TIMEOUT - 1);
    localparam logic [CH_W-1:0]  LAST_CH   = CH_W'(NUM_CH - 1);

    mcu_state_t        state, next_state;
    logic [CH_W-1:0]   kch, cur_ch_q, rr_ptr, grant_idx;
    logic [CNT_W-1:0]  word_cnt;
    logic [TMR_W-1:0]  gen_timer;
    logic [NUM_CH-1:0] key_valid, is_encrypt, eligible, grant;
    logic              any_grant, core_enc;

    // a channel may start a block only with data waiting, a key loaded and room for the result
    assign eligible = ~bus.rx_empty & key_valid & ~bus.tx_full;

    mcu_rr_arbiter #(.NUM_CH(NUM_CH), .CH_W(CH_W)) u_arb (
        .req       (eligible),
        .ptr       (rr_ptr),
        .grant     (grant),
        .idx       (grant_idx),
        .any_grant (any_grant)
    );

    assign bus.cur_ch          = cur_ch_q;
    assign bus.core_is_encrypt = core_enc;

    // next state and single-cycle strobes
    always_comb begin
        next_state     = state;
        bus.read_fifo  = 1'b0;
        bus.mcu_key_in = 1'b0;
        bus.rcv_deq    = '0;
        bus.trans_enq  = '0;
        case (state)
            IDLE: begin
                if (bus.key_in)      next_state = KEY_READ;
                else if (any_grant)  next_state = DATA_REQ;
            end
            KEY_READ: begin
                if (!bus.rx_empty[kch]) begin
                    bus.mcu_key_in   = 1'b1;
                    bus.rcv_deq[kch] = 1'b1;
                    if (word_cnt == LAST_WORD) next_state = KEY_GEN;
                end
            end
            KEY_GEN: begin
                if (bus.generation_done || gen_timer == LAST_TICK) next_state = IDLE;
            end
            DATA_REQ: begin
                bus.read_fifo = 1'b1;
                if (bus.accepted) next_state = DATA_DEQ;
            end
            DATA_DEQ: begin
                bus.rcv_deq[cur_ch_q] = 1'b1;
                next_state            = DATA_BUSY;
            end
            DATA_BUSY: begin
                if (bus.data_done) begin
                    bus.trans_enq[cur_ch_q] = 1'b1;
                    next_state              = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // state register
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    // key load bookkeeping, block ownership, round-robin pointer and error flag
    always_ff @(posedge clk) begin
        if (reset) begin
            kch       <= '0;
            word_cnt  <= '0;
            gen_timer <= '0;
            cur_ch_q  <= '0;
            core_enc  <= 1'b1;
            rr_ptr    <= '0;
            key_valid <= '0;
            gen_error <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.key_in) begin
                        kch                 <= bus.key_ch;
                        key_valid[bus.key_ch] <= 1'b0;
                        word_cnt            <= '0;
                    end else if (any_grant) begin
                        cur_ch_q <= grant_idx;
                        core_enc <= |(grant & is_encrypt);
                    end
                end
                KEY_READ: begin
                    if (!bus.rx_empty[kch]) begin
                        word_cnt  <= word_cnt + 1'b1;
                        gen_timer <= '0;
                    end
                end
                KEY_GEN: begin
                    gen_timer <= gen_timer + 1'b1;
                    if (bus.generation_done)        key_valid[kch] <= 1'b1;
                    else if (gen_timer == LAST_TICK) gen_error     <= 1'b1;
                end
                DATA_BUSY: begin
                    if (bus.data_done) rr_ptr <= (cur_ch_q == LAST_CH) ? '0 : cur_ch_q + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // per-channel direction; encrypt wins when both pulses arrive together
    always_ff @(posedge clk) begin
        if (reset) is_encrypt <= '1;
        else       is_encrypt <= enc_pulse | (is_encrypt & ~dec_pulse);
    end

    // registered status snapshot per channel
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_CH; i++) begin
            if (reset) begin
                status_bits[4*i+ST_RXFULL] <= 1'b0;
                status_bits[4*i+ST_TXNE]   <= 1'b0;
                status_bits[4*i+ST_ENC]    <= 1'b1;
                status_bits[4*i+ST_KEYV]   <= 1'b0;
            end else begin
                status_bits[4*i+ST_RXFULL] <= bus.rx_full[i];
                status_bits[4*i+ST_TXNE]   <= ~bus.tx_empty[i];
                status_bits[4*i+ST_ENC]    <= is_encrypt[i];
                status_bits[4*i+ST_KEYV]   <= key_valid[i];
            end
        end
    end
endmodule
